// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request-classification helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE_WR,
        RESP
    } lsu_state_t;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic is_illegal(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus word-wide data-memory port of the load/store unit.
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ram_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    // LSU side.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
               MemRead, MemWrite, ram_addr, write_data
    );

    // Core and memory side.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
               MemRead, MemWrite, ram_addr, write_data
    );

endinterface

// File: rtl/lsu_align.sv
// Lane selection for loads (with sign/zero extension) and lane merge for partial stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_ext_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane out of the word and extend it to 32 bits.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    load_ext_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_ext_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_ext_o = {24'h0, byte_sel};
            F3_HU:   load_ext_o = {16'h0, half_sel};
            default: load_ext_o = word_i;
        endcase
    end

    // Replace only the addressed byte/halfword lane; other lanes keep the read-back value.
    always_comb begin
        merged_o = word_i;
        if (funct3_i == F3_B) begin
            case (addr_lo_i)
                2'd0:    merged_o[7:0]   = wdata_i[7:0];
                2'd1:    merged_o[15:8]  = wdata_i[7:0];
                2'd2:    merged_o[23:16] = wdata_i[7:0];
                default: merged_o[31:24] = wdata_i[7:0];
            endcase
        end else if (funct3_i == F3_H) begin
            if (addr_lo_i[1]) begin
                merged_o[31:16] = wdata_i[15:0];
            end else begin
                merged_o[15:0] = wdata_i[15:0];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-addressed memory, read-modify-write for SB/SH.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);

    lsu_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [31:0] ram_addr_q, ram_addr_d;

    logic        req_fault;
    logic        full_word;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] align_word;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_fault = is_illegal(bus.req_funct3, bus.req_we)
                     | is_misaligned(bus.req_funct3, bus.req_addr[1:0])
                     | ({2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS);
    assign full_word = (funct3_q == F3_W);

    // During MERGE_WR the merge source is the word captured in ACCESS, not the live bus.
    assign align_word = (state_q == MERGE_WR) ? merge_q : bus.read_data;

    lsu_align u_align (
        .word_i     (align_word),
        .funct3_i   (funct3_q),
        .addr_lo_i  (addr_lo_q),
        .wdata_i    (wdata_q),
        .load_ext_o (load_ext),
        .merged_o   (merged)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
            rdata_q    <= 32'h0;
            fault_q    <= 1'b0;
            ram_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            wdata_q    <= wdata_d;
            merge_q    <= merge_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    // Next-state: accept and classify in IDLE, capture read data in ACCESS, retire in RESP.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        ram_addr_d = ram_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d       = bus.req_we;
                    funct3_d   = bus.req_funct3;
                    addr_lo_d  = bus.req_addr[1:0];
                    wdata_d    = bus.req_wdata;
                    ram_addr_d = {2'b00, bus.req_addr[31:2]};
                    if (req_fault) begin
                        rdata_d = 32'h0;
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_ext;
                    fault_d = 1'b0;
                    state_d = RESP;
                end else if (full_word) begin
                    rdata_d = 32'h0;
                    fault_d = 1'b0;
                    state_d = RESP;
                end else begin
                    merge_d = bus.read_data;
                    state_d = MERGE_WR;
                end
            end
            MERGE_WR: begin
                rdata_d = 32'h0;
                fault_d = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode from state and are suppressed in any reset cycle.
    always_comb begin
        mem_read  = !rst && (state_q == ACCESS) && !(we_q && full_word);
        mem_write = !rst && (((state_q == ACCESS) && we_q && full_word) || (state_q == MERGE_WR));

        bus.req_ready  = (state_q == IDLE);
        bus.rsp_valid  = !rst && (state_q == RESP);
        bus.rsp_rdata  = rdata_q;
        bus.rsp_fault  = fault_q;
        bus.MemRead    = mem_read;
        bus.MemWrite   = mem_write;
        bus.ram_addr   = ram_addr_q;
        bus.write_data = 32'h0;
        if (mem_write) begin
            bus.write_data = (state_q == MERGE_WR) ? merged : wdata_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed requests, a reference memory model and
// per-cycle strobe/response comparison.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int NW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if bus ();

    load_store_unit #(
        .DEPTH_WORDS (NW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic mem_init = 1'b1;

    logic [31:0] mem [NW];
    logic [31:0] ref_mem [NW];

    typedef struct {
        int          due;
        logic        fault;
        logic [31:0] rdata;
        bit          upd;
        int          idx;
        logic [31:0] nword;
    } rsp_t;

    rsp_t        exp_q[$];
    bit          exp_rd[int];
    logic [31:0] exp_wdata[int];
    int          exp_idx[int];

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'hCAFE_F00D : 32'h1000_0000 + 32'(i);
    endfunction

    // Memory attached to the DUT: combinational read, write on the rising edge.
    assign bus.read_data = (bus.ram_addr < 32'(NW)) ? mem[bus.ram_addr[4:0]] : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_init) begin
            for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
        end else if (bus.MemWrite) begin
            mem[bus.ram_addr[4:0]] <= bus.write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference behaviour of one accepted request, accepted in the cycle numbered a.
    function automatic void model_accept(input int a, input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wd);
        rsp_t        r;
        int          size;
        int          sh;
        bit          legal;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] val;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                (!we && ((f3 == 3'd4) || (f3 == 3'd5)));
        size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        r.upd   = 1'b0;
        r.idx   = 0;
        r.nword = 32'h0;
        r.rdata = 32'h0;
        if (!legal || (int'(addr[1:0]) % size) != 0 || addr[31:2] >= 30'd32) begin
            r.due   = a + 1;
            r.fault = 1'b1;
        end else begin
            r.fault = 1'b0;
            r.idx   = int'(addr[6:2]);
            word    = ref_mem[r.idx];
            sh      = 8 * int'(addr[1:0]);
            mask    = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            if (!we) begin
                val = (word >> sh) & mask;
                if (f3 == 3'd0 && val >= 32'd128) val = val - 32'd256;
                if (f3 == 3'd1 && val >= 32'd32768) val = val - 32'd65536;
                r.rdata = val;
                r.due   = a + 2;
                exp_rd[a + 1]  = 1'b1;
                exp_idx[a + 1] = r.idx;
            end else begin
                r.nword = (word & ~(mask << sh)) | ((wd & mask) << sh);
                r.upd   = 1'b1;
                if (size == 4) begin
                    r.due = a + 2;
                    exp_wdata[a + 1] = r.nword;
                    exp_idx[a + 1]   = r.idx;
                end else begin
                    r.due = a + 3;
                    exp_rd[a + 1]    = 1'b1;
                    exp_idx[a + 1]   = r.idx;
                    exp_wdata[a + 2] = r.nword;
                    exp_idx[a + 2]   = r.idx;
                end
            end
        end
        exp_q.push_back(r);
    endfunction

    // Compare process: every cycle, strobes and response against the model.
    always @(negedge clk) begin
        bit e_rd;
        bit e_wr;
        bit e_rsp;
        if (mem_init) begin
            for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        end else if (mon_en) begin
            if (rst) begin
                exp_q.delete();
                exp_rd.delete();
                exp_wdata.delete();
                exp_idx.delete();
            end
            e_rd = exp_rd.exists(cyc);
            e_wr = exp_wdata.exists(cyc);
            chk("MemRead", 32'(bus.MemRead), 32'(e_rd));
            chk("MemWrite", 32'(bus.MemWrite), 32'(e_wr));
            chk("write_data", bus.write_data, e_wr ? exp_wdata[cyc] : 32'h0);
            if (e_rd || e_wr) chk("ram_addr", bus.ram_addr, 32'(exp_idx[cyc]));
            while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
            e_rsp = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
            if (e_rsp) begin
                chk("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
                chk("rsp_fault", 32'(bus.rsp_fault), 32'(exp_q[0].fault));
                if (exp_q[0].upd) ref_mem[exp_q[0].idx] = exp_q[0].nword;
                void'(exp_q.pop_front());
            end
            if (!rst && bus.req_valid && bus.req_ready) begin
                model_accept(cyc, bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata);
            end
        end
    end

    assert property (@(posedge clk) !(bus.MemRead && bus.MemWrite))
        else $error("FAIL strobe_overlap MemRead=%b MemWrite=%b", bus.MemRead, bus.MemWrite);

    // One request with hand-computed response and latency; starts and ends in an IDLE cycle.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_flt,
                          input int exp_lat, input string name);
        bit got;
        int lat;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (!got) begin
            chk({name, "_accept_timeout"}, 32'd0, 32'd1);
            return;
        end
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) got = 1'b1;
        end
        chk({name, "_latency"}, got ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
        chk({name, "_rdata"}, bus.rsp_rdata, exp_rd);
        chk({name, "_fault"}, 32'(bus.rsp_fault), 32'(exp_flt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc[$];
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;
        mon_en   = 1'b1;

        // Reset values.
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
        chk("rst_MemRead", 32'(bus.MemRead), 32'd0);
        chk("rst_MemWrite", 32'(bus.MemWrite), 32'd0);
        chk("rst_ram_addr", bus.ram_addr, 32'h0);
        chk("rst_write_data", bus.write_data, 32'h0);
        @(posedge clk);
        #1;

        // Word store and load-back.
        do_req(1'b1, F3_W, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, "sw08");
        chk("mem2_after_sw", mem[2], 32'hDEAD_BEEF);
        do_req(1'b0, F3_W, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, "lw08");

        // Sub-word loads with sign and zero extension.
        do_req(1'b0, F3_B,  32'h09, 32'h0, 32'hFFFF_FFBE, 1'b0, 2, "lb09");
        do_req(1'b0, F3_BU, 32'h09, 32'h0, 32'h0000_00BE, 1'b0, 2, "lbu09");
        do_req(1'b0, F3_H,  32'h0A, 32'h0, 32'hFFFF_DEAD, 1'b0, 2, "lh0a");
        do_req(1'b0, F3_HU, 32'h08, 32'h0, 32'h0000_BEEF, 1'b0, 2, "lhu08");
        do_req(1'b0, F3_B,  32'h08, 32'h0, 32'hFFFF_FFEF, 1'b0, 2, "lb08");
        do_req(1'b0, F3_HU, 32'h0A, 32'h0, 32'h0000_DEAD, 1'b0, 2, "lhu0a");

        // Read-modify-write byte and halfword stores.
        do_req(1'b1, F3_B, 32'h0B, 32'h0000_0011, 32'h0, 1'b0, 3, "sb0b");
        do_req(1'b0, F3_W, 32'h08, 32'h0, 32'h11AD_BEEF, 1'b0, 2, "lw08_after_sb");
        do_req(1'b1, F3_H, 32'h0E, 32'hFFFF_8001, 32'h0, 1'b0, 3, "sh0e");
        do_req(1'b0, F3_H, 32'h0E, 32'h0, 32'hFFFF_8001, 1'b0, 2, "lh0e");
        do_req(1'b0, F3_W, 32'h0C, 32'h0, 32'h8001_0003, 1'b0, 2, "lw0c");

        // Faults: misaligned, out of range, illegal funct3.
        do_req(1'b0, F3_W,   32'h06, 32'h0, 32'h0, 1'b1, 1, "lw06_misaligned");
        do_req(1'b1, F3_H,   32'h05, 32'h1234, 32'h0, 1'b1, 1, "sh05_misaligned");
        do_req(1'b0, F3_W,   32'h80, 32'h0, 32'h0, 1'b1, 1, "lw80_range");
        do_req(1'b1, F3_W,   32'h7C, 32'h5555_5555, 32'h0, 1'b0, 2, "sw7c_last");
        do_req(1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1, "f3_011");
        do_req(1'b1, F3_BU,  32'h00, 32'hAA, 32'h0, 1'b1, 1, "sbu_store");
        chk("mem0_after_faults", mem[0], 32'h1000_0000);

        // Reset during the MERGE_WR cycle of SH 0x04: the write must be dropped.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_H;
        bus.req_addr   = 32'h04;
        bus.req_wdata  = 32'h0000_1234;
        @(negedge clk);
        chk("sh04_accept_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("sh04_access_read", 32'(bus.MemRead), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("sh04_rst_no_write", 32'(bus.MemWrite), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("sh04_ready_after_rst", 32'(bus.req_ready), 32'd1);
        chk("sh04_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("mem1_unchanged", mem[1], 32'hCAFE_F00D);
        @(posedge clk);
        #1;

        // Back-to-back loads with req_valid held: accepts every third cycle.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h08;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus.req_ready) acc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("b2b_accept_count", 32'(acc.size()), 32'd3);
        for (int i = 1; i < acc.size(); i++) begin
            chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
        end
        repeat (4) @(posedge clk);
        #1;

        // Final memory image against the reference model.
        for (int i = 0; i < NW; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
        chk("mem31_final", mem[31], 32'h5555_5555);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
